// File: rtl/ras_pkg.sv
// Shared constants and command type for the return-address-stack frontend.
package ras_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [4:0] LINK_RA = 5'd1;
  localparam logic [4:0] LINK_T0 = 5'd5;

  typedef struct packed {
    logic push;
    logic pop;
    logic branch;
  } ras_cmd_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_RA) || (r == LINK_T0);
  endfunction

endpackage

// File: rtl/ras_hint_decode.sv
// Combinational classifier: turns an RV32 instruction word into RAS push/pop/branch hints.
module ras_hint_decode
  import ras_pkg::*;
(
  input  logic [31:0] instr,
  output ras_cmd_t    cmd
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic       rd_link;
  logic       rs1_link;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign rd          = instr[11:7];
  assign rs1         = instr[19:15];
  assign rd_link     = is_link(rd);
  assign rs1_link    = is_link(rs1);
  assign unused_bits = ^{instr[31:20], instr[14:12]};

  always_comb begin
    cmd = '0;
    case (opcode)
      OP_JAL:    cmd.push = rd_link;
      OP_JALR: begin
        // Coroutine swap (both link, different regs) pops and pushes together.
        cmd.push = rd_link;
        cmd.pop  = rs1_link && (!rd_link || (rd != rs1));
      end
      OP_BRANCH: cmd.branch = 1'b1;
      default:   cmd = '0;
    endcase
  end

endmodule

// File: rtl/ras_frontend.sv
// Fetch-side RAS command generator: accepts instructions, tracks unresolved branches,
// and issues registered push/pop/branch/close pulses one cycle after accept/resolve.
module ras_frontend
  import ras_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int MAXBRANCHES   = 16,
  parameter int BRANCHES_ADDR = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_pc,
  input  logic [31:0]            in_instr,
  input  logic                   res_valid,
  input  logic                   res_correct,
  output logic                   ras_push,
  output logic                   ras_pop,
  output logic                   ras_branch,
  output logic                   ras_close_valid,
  output logic                   ras_close_invalid,
  output logic [WIDTH-1:0]       ras_din,
  output logic [BRANCHES_ADDR:0] outstanding,
  output logic                   err_underflow
);

  localparam logic [BRANCHES_ADDR:0] MAX_CNT = (BRANCHES_ADDR + 1)'(MAXBRANCHES);

  ras_cmd_t                 dec_cmd;
  ras_cmd_t                 cmd;
  logic [BRANCHES_ADDR:0]   cnt;
  logic [BRANCHES_ADDR:0]   cnt_next;
  logic                     mispredict;
  logic                     accept;
  logic                     have_open;
  logic                     close_v;
  logic                     close_i;

  ras_hint_decode u_decode (
    .instr (in_instr),
    .cmd   (dec_cmd)
  );

  // Handshake: an instruction transfers when in_valid && in_ready on a rising edge.
  // in_ready drops when the checkpoint FIFO is full, while a mispredict flushes,
  // and during reset; in_valid may be held or withdrawn freely.
  assign mispredict = res_valid && !res_correct;
  assign in_ready   = !rst && (cnt != MAX_CNT) && !mispredict;
  assign accept     = in_valid && in_ready;
  assign cmd        = accept ? dec_cmd : '0;

  assign have_open  = (cnt != '0);
  assign close_v    = res_valid && res_correct && have_open;
  assign close_i    = mispredict && have_open;

  always_comb begin
    cnt_next = cnt;
    if (close_i) begin
      cnt_next = '0;
    end else if (cmd.branch && !close_v) begin
      cnt_next = cnt + 1'b1;
    end else if (!cmd.branch && close_v) begin
      cnt_next = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt               <= '0;
      ras_push          <= 1'b0;
      ras_pop           <= 1'b0;
      ras_branch        <= 1'b0;
      ras_close_valid   <= 1'b0;
      ras_close_invalid <= 1'b0;
      ras_din           <= '0;
      err_underflow     <= 1'b0;
    end else begin
      cnt               <= cnt_next;
      ras_push          <= cmd.push;
      ras_pop           <= cmd.pop;
      ras_branch        <= cmd.branch;
      ras_close_valid   <= close_v;
      ras_close_invalid <= close_i;
      if (cmd.push) begin
        ras_din <= in_pc + WIDTH'(4);
      end
      if (res_valid && !have_open) begin
        err_underflow <= 1'b1;
      end
    end
  end

  assign outstanding = cnt;

endmodule

// File: tb/tb_ras_frontend.sv
// Bench for ras_frontend: directed vector table, multi-cycle corner sequences,
// and a randomized phase checked against a behavioural model.
module tb_ras_frontend;

  typedef struct packed {
    logic        push;
    logic        pop;
    logic        branch;
    logic        cv;
    logic        ci;
    logic [31:0] din;
    logic [4:0]  outst;
    logic        err;
  } exp_t;

  localparam int EW = $bits(exp_t);

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        rv;
    logic        rc;
    logic        rdy;
    exp_t        e;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        push;
    logic        pop;
    logic        branch;
  } pool_t;

  localparam logic [31:0] I_JAL_X1   = 32'h0000_00EF;
  localparam logic [31:0] I_JAL_X5   = 32'h0000_02EF;
  localparam logic [31:0] I_JAL_X0   = 32'h0000_006F;
  localparam logic [31:0] I_RET      = 32'h0000_8067;
  localparam logic [31:0] I_JALR_5_1 = 32'h0000_82E7;
  localparam logic [31:0] I_JALR_1_1 = 32'h0000_80E7;
  localparam logic [31:0] I_JALR_1_5 = 32'h0002_80E7;
  localparam logic [31:0] I_JALR_0_2 = 32'h0001_0067;
  localparam logic [31:0] I_JALR_2_1 = 32'h0000_8167;
  localparam logic [31:0] I_JALR_1_2 = 32'h0001_00E7;
  localparam logic [31:0] I_BEQ      = 32'h0000_0063;
  localparam logic [31:0] I_BNE      = 32'h0000_1063;
  localparam logic [31:0] I_ADDI     = 32'h0010_8093;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        res_valid;
  logic        res_correct;
  logic        ras_push;
  logic        ras_pop;
  logic        ras_branch;
  logic        ras_close_valid;
  logic        ras_close_invalid;
  logic [31:0] ras_din;
  logic [4:0]  outstanding;
  logic        err_underflow;

  logic [EW-1:0] exp_q[$];
  int            n_vec;
  int            n_miss;

  ras_frontend dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_pc             (in_pc),
    .in_instr          (in_instr),
    .res_valid         (res_valid),
    .res_correct       (res_correct),
    .ras_push          (ras_push),
    .ras_pop           (ras_pop),
    .ras_branch        (ras_branch),
    .ras_close_valid   (ras_close_valid),
    .ras_close_invalid (ras_close_invalid),
    .ras_din           (ras_din),
    .outstanding       (outstanding),
    .err_underflow     (err_underflow)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mke(input logic push, pop, br, cv, ci,
                               input logic [31:0] din, input int outst, input logic err);
    exp_t e;
    e.push = push; e.pop = pop; e.branch = br; e.cv = cv; e.ci = ci;
    e.din = din; e.outst = 5'(outst); e.err = err;
    return e;
  endfunction

  function automatic vec_t mkv(input logic r, iv, input logic [31:0] instr, pc,
                               input logic rv, rc, rdy, input exp_t e);
    vec_t v;
    v.rst = r; v.iv = iv; v.instr = instr; v.pc = pc;
    v.rv = rv; v.rc = rc; v.rdy = rdy; v.e = e;
    return v;
  endfunction

  function automatic exp_t got_now();
    return mke(ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid,
               ras_din, int'(outstanding), err_underflow);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Driver: apply inputs after the falling edge, queue the expectation,
  // then score the registered outputs just after the next rising edge.
  task automatic run_vec(input vec_t v, input string name);
    exp_t e;
    rst = v.rst; in_valid = v.iv; in_instr = v.instr; in_pc = v.pc;
    res_valid = v.rv; res_correct = v.rc;
    #1;
    check({name, "/in_ready"}, 64'(in_ready), 64'(v.rdy));
    exp_q.push_back(v.e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++; n_miss++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_t'(exp_q.pop_front());
      check({name, "/outputs"}, 64'(got_now()), 64'(e));
    end
    @(negedge clk);
  endtask

  vec_t  tbl[20];
  pool_t pool[13];

  initial begin
    exp_t  z;
    int    m_out;
    logic  m_err;
    logic [31:0] m_din;

    n_vec = 0; n_miss = 0;
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    res_valid = 1'b0; res_correct = 1'b0;
    z = mke(0, 0, 0, 0, 0, 32'h0, 0, 0);

    tbl[0]  = mkv(0, 1, I_JAL_X1,   32'h0000_1000, 0, 0, 1, mke(1, 0, 0, 0, 0, 32'h0000_1004, 0, 0));
    tbl[1]  = mkv(0, 1, I_RET,      32'h0000_1100, 0, 0, 1, mke(0, 1, 0, 0, 0, 32'h0000_1004, 0, 0));
    tbl[2]  = mkv(0, 1, I_JALR_5_1, 32'h0000_2000, 0, 0, 1, mke(1, 1, 0, 0, 0, 32'h0000_2004, 0, 0));
    tbl[3]  = mkv(0, 1, I_JALR_1_1, 32'h0000_3000, 0, 0, 1, mke(1, 0, 0, 0, 0, 32'h0000_3004, 0, 0));
    tbl[4]  = mkv(0, 1, I_JALR_1_5, 32'h0000_4000, 0, 0, 1, mke(1, 1, 0, 0, 0, 32'h0000_4004, 0, 0));
    tbl[5]  = mkv(0, 1, I_JALR_0_2, 32'h0000_4100, 0, 0, 1, mke(0, 0, 0, 0, 0, 32'h0000_4004, 0, 0));
    tbl[6]  = mkv(0, 1, I_JAL_X0,   32'h0000_4200, 0, 0, 1, mke(0, 0, 0, 0, 0, 32'h0000_4004, 0, 0));
    tbl[7]  = mkv(0, 1, I_ADDI,     32'h0000_4300, 0, 0, 1, mke(0, 0, 0, 0, 0, 32'h0000_4004, 0, 0));
    tbl[8]  = mkv(0, 0, I_JAL_X1,   32'h0000_9000, 0, 0, 1, mke(0, 0, 0, 0, 0, 32'h0000_4004, 0, 0));
    tbl[9]  = mkv(0, 1, I_JAL_X5,   32'h0000_5000, 0, 0, 1, mke(1, 0, 0, 0, 0, 32'h0000_5004, 0, 0));
    tbl[10] = mkv(0, 1, I_BEQ,      32'h0000_5100, 0, 0, 1, mke(0, 0, 1, 0, 0, 32'h0000_5004, 1, 0));
    tbl[11] = mkv(0, 1, I_BNE,      32'h0000_5200, 0, 0, 1, mke(0, 0, 1, 0, 0, 32'h0000_5004, 2, 0));
    tbl[12] = mkv(0, 0, I_BEQ,      32'h0000_5300, 1, 1, 1, mke(0, 0, 0, 1, 0, 32'h0000_5004, 1, 0));
    tbl[13] = mkv(0, 1, I_BEQ,      32'h0000_5400, 1, 1, 1, mke(0, 0, 1, 1, 0, 32'h0000_5004, 1, 0));
    tbl[14] = mkv(0, 1, I_JAL_X1,   32'h0000_6000, 1, 0, 0, mke(0, 0, 0, 0, 1, 32'h0000_5004, 0, 0));
    tbl[15] = mkv(0, 0, I_ADDI,     32'h0000_6100, 1, 1, 1, mke(0, 0, 0, 0, 0, 32'h0000_5004, 0, 1));
    tbl[16] = mkv(0, 1, I_JAL_X1,   32'hFFFF_FFFC, 0, 0, 1, mke(1, 0, 0, 0, 0, 32'h0000_0000, 0, 1));
    tbl[17] = mkv(1, 1, I_JAL_X1,   32'h0000_0100, 0, 0, 0, z);
    tbl[18] = mkv(0, 0, I_ADDI,     32'h0000_0200, 1, 0, 0, mke(0, 0, 0, 0, 0, 32'h0000_0000, 0, 1));
    tbl[19] = mkv(1, 1, I_BEQ,      32'h0000_0300, 1, 1, 0, z);

    pool[0]  = '{I_JAL_X1,   1, 0, 0};
    pool[1]  = '{I_JAL_X5,   1, 0, 0};
    pool[2]  = '{I_JAL_X0,   0, 0, 0};
    pool[3]  = '{I_RET,      0, 1, 0};
    pool[4]  = '{I_JALR_5_1, 1, 1, 0};
    pool[5]  = '{I_JALR_1_1, 1, 0, 0};
    pool[6]  = '{I_JALR_1_5, 1, 1, 0};
    pool[7]  = '{I_JALR_0_2, 0, 0, 0};
    pool[8]  = '{I_JALR_2_1, 0, 1, 0};
    pool[9]  = '{I_JALR_1_2, 1, 0, 0};
    pool[10] = '{I_BEQ,      0, 0, 1};
    pool[11] = '{I_BNE,      0, 0, 1};
    pool[12] = '{I_ADDI,     0, 0, 0};

    // Reset state
    @(negedge clk);
    run_vec(mkv(1, 1, I_JAL_X1, 32'h0000_0040, 1, 0, 0, z), "reset0");
    run_vec(mkv(1, 0, I_ADDI,   32'h0000_0000, 0, 0, 0, z), "reset1");

    for (int i = 0; i < 20; i++) begin
      run_vec(tbl[i], $sformatf("tbl%0d", i));
    end

    // Fill the checkpoint FIFO, then drain one slot.
    for (int i = 0; i < 16; i++) begin
      run_vec(mkv(0, 1, I_BEQ, 32'h100 + 32'(4 * i), 0, 0, 1,
                  mke(0, 0, 1, 0, 0, 32'h0, i + 1, 0)), $sformatf("fill%0d", i));
    end
    run_vec(mkv(0, 1, I_BEQ, 32'h200, 0, 0, 0, mke(0, 0, 0, 0, 0, 32'h0, 16, 0)), "full_stall");
    run_vec(mkv(0, 1, I_BEQ, 32'h204, 1, 1, 0, mke(0, 0, 0, 1, 0, 32'h0, 15, 0)), "full_resolve");
    run_vec(mkv(0, 0, I_BEQ, 32'h208, 0, 0, 1, mke(0, 0, 0, 0, 0, 32'h0, 15, 0)), "ready_again");
    for (int i = 0; i < 10; i++) begin
      run_vec(mkv(0, 0, I_ADDI, 32'h0, 1, 1, 1, mke(0, 0, 0, 1, 0, 32'h0, 14 - i, 0)),
              $sformatf("drain%0d", i));
    end
    run_vec(mkv(0, 1, I_BEQ, 32'h300, 1, 1, 1, mke(0, 0, 1, 1, 0, 32'h0, 5, 0)), "br_and_close");
    run_vec(mkv(0, 0, I_ADDI, 32'h0, 1, 1, 1, mke(0, 0, 0, 1, 0, 32'h0, 4, 0)), "drain_a");
    run_vec(mkv(0, 0, I_ADDI, 32'h0, 1, 1, 1, mke(0, 0, 0, 1, 0, 32'h0, 3, 0)), "drain_b");
    run_vec(mkv(0, 1, I_JAL_X1, 32'h400, 1, 0, 0, mke(0, 0, 0, 0, 1, 32'h0, 0, 0)), "flush_jal");

    // Randomized traffic against a behavioural model.
    m_out = 0; m_err = 1'b0; m_din = 32'h0;
    for (int i = 0; i < 400; i++) begin
      vec_t  v;
      pool_t p;
      logic  acc;
      logic  open;
      p = pool[$urandom_range(0, 12)];
      v.rst   = ($urandom_range(0, 39) == 0);
      v.iv    = ($urandom_range(0, 3) != 0);
      v.instr = p.instr;
      v.pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      v.rv    = ($urandom_range(0, 3) == 0);
      v.rc    = ($urandom_range(0, 3) != 0);
      v.rdy   = !v.rst && (m_out != 16) && !(v.rv && !v.rc);
      acc     = v.iv && v.rdy;
      open    = (m_out != 0);
      if (v.rst) begin
        m_out = 0; m_err = 1'b0; m_din = 32'h0;
        v.e = z;
      end else begin
        if (acc && p.push) m_din = v.pc + 32'd4;
        if (v.rv && !open) m_err = 1'b1;
        v.e = mke(acc && p.push, acc && p.pop, acc && p.branch,
                  v.rv && v.rc && open, v.rv && !v.rc && open, m_din, 0, m_err);
        if (v.rv && !v.rc && open) m_out = 0;
        else m_out = m_out + ((acc && p.branch) ? 1 : 0) - ((v.rv && v.rc && open) ? 1 : 0);
        v.e.outst = 5'(m_out);
      end
      run_vec(v, $sformatf("rand%0d", i));
    end

    if (exp_q.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
